// File: rtl/debug_frame_unit.sv
// Host debug controller: decodes single-byte commands, gates the core enable and
// streams a framed snapshot of debug_signal (header, MSB-first payload, XOR checksum).
module debug_frame_unit #(
  parameter int          DBG_W    = 1416,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd,
  input  logic             tx_full,
  output logic [7:0]       w_data,
  output logic             wr,
  input  logic [DBG_W-1:0] debug_signal,
  output logic             enable,
  output logic             busy
);
  // state  | meaning
  // IDLE   | core halted, accepting commands
  // RUN    | core free-running, only 'h' acts
  // STEP   | single enabled cycle
  // LATCH  | capture snapshot, clear idx/chk
  // HDR    | send header byte
  // DATA   | send payload bytes, MSB first
  // CSUM   | send XOR of payload bytes
  localparam int NBYTES = (DBG_W + 7) / 8;
  localparam int PW     = NBYTES * 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [7:0] CMD_C = 8'h63;
  localparam logic [7:0] CMD_H = 8'h68;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_D = 8'h64;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_LATCH, S_HDR, S_DATA, S_CSUM
  } state_t;

  state_t           r_state;
  logic [DBG_W-1:0] r_snap;
  logic [IW-1:0]    r_idx;
  logic [7:0]       r_chk;
  logic             r_enable;
  logic             r_busy;

  logic [PW-1:0]    w_pad;
  logic [IW-1:0]    w_sel;
  logic [7:0]       w_byte;
  logic             w_pop;
  logic             w_last;
  logic             w_tx_state;

  // zero-extension pads the top of byte 0 when DBG_W is not a multiple of 8
  assign w_pad      = PW'(r_snap);
  assign w_sel      = IW'(NBYTES - 1) - r_idx;
  assign w_byte     = w_pad[{w_sel, 3'b000} +: 8];
  assign w_last     = (r_idx == IW'(NBYTES - 1));
  assign w_pop      = reset && !rx_empty && (r_state == S_IDLE || r_state == S_RUN);
  assign w_tx_state = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);

  // FIFO strobes stay combinational so a pop/push lands in the same cycle as the decision
  assign rd     = w_pop;
  assign wr     = w_tx_state && !tx_full;
  assign enable = r_enable;
  assign busy   = r_busy;

  always_comb begin
    w_data = 8'h00;
    case (r_state)
      S_HDR:   w_data = HDR_BYTE;
      S_DATA:  w_data = w_byte;
      S_CSUM:  w_data = r_chk;
      default: w_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_snap   <= '0;
      r_idx    <= '0;
      r_chk    <= 8'h00;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_enable <= 1'b0;
          if (w_pop) begin
            case (r_data)
              CMD_C: begin r_state <= S_RUN;   r_enable <= 1'b1; end
              CMD_S: begin r_state <= S_STEP;  r_enable <= 1'b1; end
              CMD_D: begin r_state <= S_LATCH; r_busy   <= 1'b1; end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          if (w_pop && r_data == CMD_H) begin
            r_state  <= S_LATCH;
            r_enable <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_STEP: begin
          r_state  <= S_LATCH;
          r_enable <= 1'b0;
          r_busy   <= 1'b1;
        end
        S_LATCH: begin
          r_snap  <= debug_signal;
          r_chk   <= 8'h00;
          r_idx   <= '0;
          r_state <= S_HDR;
        end
        S_HDR: begin
          if (!tx_full) r_state <= S_DATA;
        end
        S_DATA: begin
          if (!tx_full) begin
            r_chk <= r_chk ^ w_byte;
            if (w_last) r_state <= S_CSUM;
            else        r_idx   <= r_idx + 1'b1;
          end
        end
        S_CSUM: begin
          if (!tx_full) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
